// File: rtl/cerradura_pkg.sv
// Shared types and helpers for the sequential combination lock.
package cerradura_pkg;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CAPTURA = 2'd1,
    ABIERTO = 2'd2,
    BLOQUEO = 2'd3
  } estado_t;

  localparam int CLAVE_MAX = 64;

  // Digit 0 sits in the most significant pair of the key.
  function automatic logic [1:0] digito_clave(input logic [CLAVE_MAX-1:0] clave,
                                              input int n, input int i);
    logic [1:0] d;
    d = 2'b00;
    if (i >= 0 && i < n) d = clave[2*(n-1-i) +: 2];
    return d;
  endfunction

endpackage

// File: rtl/cerradura_secuencial_comparador.sv
// 2-bit equality comparator; purely combinational.
module comparador (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       aeqb
);

  assign aeqb = (a == b);

endmodule

// File: rtl/cerradura_secuencial.sv
// Sequential combination lock: checks one 2-bit symbol per accepted cycle against CLAVE,
// with unlock window, failed-attempt counting, lockout and inactivity timeout.
module cerradura_secuencial
  import cerradura_pkg::*;
#(
  parameter int                   N_DIGITOS    = 4,
  parameter logic [2*N_DIGITOS-1:0] CLAVE      = 8'b10_01_11_00,
  parameter int                   MAX_INTENTOS = 3,
  parameter int                   T_ABIERTO    = 8,
  parameter int                   T_BLOQUEO    = 16,
  parameter int                   T_INACT      = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         dato,
  input  logic                               valido,
  output logic                               abrir,
  output logic                               error,
  output logic                               bloqueo,
  output logic [$clog2(N_DIGITOS+1)-1:0]     digitos,
  output logic [$clog2(MAX_INTENTOS+1)-1:0]  intentos
);

  localparam int DW    = $clog2(N_DIGITOS+1);
  localparam int IW    = $clog2(MAX_INTENTOS+1);
  localparam int T_AB  = (T_ABIERTO > T_BLOQUEO) ? T_ABIERTO : T_BLOQUEO;
  localparam int T_MAX = (T_AB > T_INACT) ? T_AB : T_INACT;
  localparam int TW    = $clog2(T_MAX) + 1;

  localparam logic [CLAVE_MAX-1:0] CLAVE_EXT = CLAVE_MAX'(CLAVE);
  localparam logic [DW-1:0]        ULTIMO    = DW'(N_DIGITOS-1);
  localparam logic [IW-1:0]        INT_MAX   = IW'(MAX_INTENTOS);

  estado_t          estado, estado_n;
  logic [DW-1:0]    digitos_n;
  logic [IW-1:0]    intentos_n;
  logic             falla, falla_n;
  logic [TW-1:0]    timer, timer_n;
  logic             error_n;
  logic [1:0]       digito_ref;
  logic             aeqb;

  assign digito_ref = digito_clave(CLAVE_EXT, N_DIGITOS, int'(digitos));

  comparador u_comparador (
    .a    (dato),
    .b    (digito_ref),
    .aeqb (aeqb)
  );

  always_comb begin
    estado_n   = estado;
    digitos_n  = digitos;
    intentos_n = intentos;
    falla_n    = falla;
    timer_n    = timer;
    error_n    = 1'b0;
    case (estado)
      ESPERA: begin
        if (valido) begin
          digitos_n = DW'(1);
          falla_n   = ~aeqb;
          timer_n   = TW'(T_INACT-1);
          estado_n  = CAPTURA;
        end
      end
      CAPTURA: begin
        if (valido) begin
          if (digitos == ULTIMO) begin
            digitos_n = '0;
            falla_n   = 1'b0;
            if (!falla && aeqb) begin
              estado_n   = ABIERTO;
              intentos_n = '0;
              timer_n    = TW'(T_ABIERTO-1);
            end else begin
              error_n    = 1'b1;
              intentos_n = (intentos == INT_MAX) ? intentos : intentos + IW'(1);
              if (intentos_n == INT_MAX) begin
                estado_n = BLOQUEO;
                timer_n  = TW'(T_BLOQUEO-1);
              end else begin
                estado_n = ESPERA;
                timer_n  = '0;
              end
            end
          end else begin
            digitos_n = digitos + DW'(1);
            falla_n   = falla | ~aeqb;
            timer_n   = TW'(T_INACT-1);
          end
        end else if (timer == '0) begin
          // Abandoned partial code: discard silently, attempts untouched.
          estado_n  = ESPERA;
          digitos_n = '0;
          falla_n   = 1'b0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      ABIERTO: begin
        if (timer == '0) estado_n = ESPERA;
        else             timer_n  = timer - TW'(1);
      end
      BLOQUEO: begin
        if (timer == '0) begin
          estado_n   = ESPERA;
          intentos_n = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: estado_n = ESPERA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= ESPERA;
      digitos  <= '0;
      intentos <= '0;
      falla    <= 1'b0;
      timer    <= '0;
      error    <= 1'b0;
      abrir    <= 1'b0;
      bloqueo  <= 1'b0;
    end else begin
      estado   <= estado_n;
      digitos  <= digitos_n;
      intentos <= intentos_n;
      falla    <= falla_n;
      timer    <= timer_n;
      error    <= error_n;
      abrir    <= (estado_n == ABIERTO);
      bloqueo  <= (estado_n == BLOQUEO);
    end
  end

endmodule

// File: doc/cerradura_secuencial.md
# cerradura_secuencial

Sequential combination lock that consumes a stream of 2-bit symbols and checks them, one per accepted symbol, against a stored key. Each symbol is checked through the team's 2-bit equality comparator. An internal FSM tracks digit position, failed attempts, an unlock window and a lockout period. The block sits directly downstream of the equality comparator and turns its per-symbol `aeqb` result into registered open, error and lockout signals.

## Interface
- `N_DIGITOS`, 4: symbols per code; must be ≥ 2.
- `CLAVE`, 8'b10_01_11_00: key, width 2·N_DIGITOS; digit 0 is the MSB pair.
- `MAX_INTENTOS`, 3: consecutive failed codes that trigger lockout; must be ≥ 1.
- `T_ABIERTO`, 8: cycles `abrir` stays high.
- `T_BLOQUEO`, 16: cycles `bloqueo` stays high.
- `T_INACT`, 32: idle cycles allowed between digits before a partial code is discarded.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dato` in 2: entered symbol.
- `valido` in 1: `dato` is accepted on a rising edge while `valido`=1 and state is ESPERA or CAPTURA.
- `abrir` out 1: unlock window active.
- `error` out 1: one-cycle pulse on a wrong complete code.
- `bloqueo` out 1: lockout active.
- `digitos` out $clog2(N_DIGITOS+1): number of symbols accepted in the current code.
- `intentos` out $clog2(MAX_INTENTOS+1): consecutive failed codes.

## Operation
- States: ESPERA, CAPTURA, ABIERTO, BLOQUEO. Reset enters ESPERA.
- Comparison for symbol i: `dato` vs `CLAVE[2(N_DIGITOS-1-i)+1 : 2(N_DIGITOS-1-i)]`, using a sticky mismatch flag `falla`.
- ESPERA:
  - `valido`=1 → accept digit 0; `digitos`←1; `falla`←~aeqb; go to CAPTURA.
  - Otherwise stay.
- CAPTURA, `valido`=1, not the last digit:
  - `digitos`++; `falla` |= ~aeqb; inactivity timer cleared.
- CAPTURA, `valido`=1, last digit (`digitos`=N_DIGITOS-1). Let `ok` = ~(falla | ~aeqb).
  - `ok`: go to ABIERTO; `intentos`←0; `digitos`←0.
  - Not `ok`: `error` pulses; `intentos`++; `digitos`←0.
    - If the new `intentos` = MAX_INTENTOS → BLOQUEO.
    - Otherwise → ESPERA.
- CAPTURA, no `valido` for T_INACT consecutive cycles:
  - Go to ESPERA; `digitos`←0; `falla`←0.
  - No error pulse; `intentos` is unchanged.
- ABIERTO:
  - `abrir`=1 for exactly T_ABIERTO cycles, then ESPERA.
  - `valido` is ignored; symbols are dropped, not queued.
- BLOQUEO:
  - `bloqueo`=1 for exactly T_BLOQUEO cycles, then ESPERA with `intentos`←0.
  - `valido` is ignored.
- One shared down-counter serves the ABIERTO, BLOQUEO and inactivity timers. Its width is $clog2 of the largest T_* value plus 1.
- Counter arithmetic: no wrap. `intentos` saturates at MAX_INTENTOS, and is reset in BLOQUEO before it can overflow.

## Timing
- All outputs are registered; none are combinational from `dato` or `valido`.
- Reset values: `abrir`=0, `error`=0, `bloqueo`=0, `digitos`=0, `intentos`=0. Internal: `falla`=0, timer=0, state=ESPERA.
- Last digit accepted on edge k:
  - `abrir` or `error` is high in the cycle after edge k.
  - `abrir` falls after edge k+T_ABIERTO.
- `error` is high for exactly one cycle. When the same failure triggers lockout, `bloqueo` rises in that same cycle.
- Digits may arrive on back-to-back cycles: a full code can be entered in N_DIGITOS consecutive cycles.
- `valido` on the cycle `abrir` or `bloqueo` falls is ignored. A symbol is accepted only from the first ESPERA cycle.
- Inactivity timeout fires on the T_INACT-th consecutive idle cycle. A `valido` in that same cycle takes priority: the digit is accepted and the timer is cleared.
- `rst` mid-operation immediately returns every register to its reset value, including `intentos`.

## Structure
- Package `cerradura_pkg`:
  - State enum/localparams (ESPERA, CAPTURA, ABIERTO, BLOQUEO).
  - Helper function returning the key digit at index i.
- Sub-module: one instance of the existing `comparador` (ports a, b, aeqb).
  - a = `dato`; b = selected key digit.
  - Its `aeqb` feeds the FSM.

## Test plan
Defaults: CLAVE=10_01_11_00, MAX_INTENTOS=3, T_ABIERTO=8, T_BLOQUEO=16, T_INACT=32.

- Correct code: digits 2,1,3,0 on consecutive cycles → `abrir`=1 for 8 cycles starting the cycle after digit 3; `intentos`=0; `error` never high.
- Wrong last digit: 2,1,3,1 → one-cycle `error`; `intentos`=1; `abrir` stays 0; `digitos` returns to 0.
- Three wrong codes (0,0,0,0 ×3) → `error` pulses 3 times; on the third, `bloqueo`=1 for 16 cycles; then `intentos`=0.
- During BLOQUEO, enter 2,1,3,0 → ignored; `abrir` stays 0 and `digitos` stays 0.
- Timeout: enter 2,1, idle 32 cycles, then 2,1,3,0 → no `error`; `intentos` unchanged; `abrir` asserted.
- `rst` pulse after digits 2,1 with `intentos`=2 → all outputs 0 immediately; then a correct code opens normally.
